data_count_fsm: RTL and testbench
=================================

Name: data_count_fsm

Overview:
- Parametrised successor to the fixed four-ones flag detector.
- Counts qualifying data=1 samples against a run-time threshold and pulses flag one cycle after the terminal sample.
- Two modes: cumulative (zeros hold the count) and consecutive (zeros restart the count).
- Adds enable gating, synchronous clear, a live count output and a saturating hit counter.
- Used as the generic event/sequence detector in the niuke-style control blocks.

Parameters:
- CNT_W, 4, width of threshold port thr and count output cnt; thresholds 1..2^CNT_W-1.
- HIT_W, 8, width of saturating hit counter hit_cnt.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear, active-high.
- en  input  1  sample qualifier; data is ignored when en=0.
- data  input  1  serial input bit.
- mode  input  1  0 = cumulative, 1 = consecutive.
- thr  input  CNT_W  number of qualifying ones per hit; 0 disables detection.
- flag  output  1  registered one-cycle hit pulse.
- cnt  output  CNT_W  ones accumulated in current run (registered).
- busy  output  1  1 while state = COUNT.
- hit_cnt  output  HIT_W  total hits since reset/clr, saturating at all-ones.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, thr_q=0, flag=0, hit_cnt=0, busy=0.
- Priority per clock edge: rst > clr > normal operation.
- clr=1: same values as reset, applied at the clock edge; data on that cycle is ignored.
- A sample qualifies when en=1 and data=1, written q below.
- States: IDLE (cnt=0), COUNT (1 <= cnt < thr_q). Registered current_state, combinational next_state, registered outputs (three-process style).
- IDLE:
  - thr_q <= thr every cycle.
  - thr=0: cnt stays 0, flag stays 0, no transition.
  - q and thr=1: flag<=1, hit_cnt increments, stay IDLE.
  - q and thr>=2: cnt<=1, go to COUNT.
  - Otherwise: stay IDLE, flag<=0.
- COUNT:
  - thr_q is frozen; changes on thr take effect only after returning to IDLE.
  - q and cnt=thr_q-1: flag<=1, hit_cnt increments, cnt<=0, go to IDLE.
  - q otherwise: cnt<=cnt+1.
  - en=1, data=0, mode=0: hold cnt and state.
  - en=1, data=0, mode=1: cnt<=0, go to IDLE, no flag.
  - en=0: hold everything; data is ignored regardless of mode.
- flag timing: high exactly one cycle, in the cycle after the terminal qualifying sample; 0 in all other cycles.
- Back-to-back hits are allowed:
  - thr=1 with continuous q gives flag high every cycle.
  - With thr>=2 a new run starts on the cycle after the hit.
- hit_cnt saturates at 2^HIT_W-1 and does not wrap. flag still pulses at saturation.
- mode may change at any time; it is evaluated per sample.
- busy = (state == COUNT), registered.
- Reset asserted mid-run aborts immediately. A flag that is high is cleared asynchronously.

Test Plan:
1. thr=4, mode=0, en=1, data=1,0,1,1,0,1 -> flag high only in the cycle after the 6th sample; cnt sequence 1,1,2,3,3,0; hit_cnt=1.
2. thr=3, mode=1, data=1,1,0,1,1,1 -> zero at sample 3 returns cnt to 0 with no flag; flag pulses after sample 6; hit_cnt=1.
3. thr=1, data=1 for 5 cycles -> flag high for 5 consecutive cycles starting one cycle after the first sample; hit_cnt=5; busy stays 0.
4. thr=4, mode=0, data=1 with en=0 on the 2nd and 4th cycles of 6 -> only 4 samples qualify; flag after the 6th cycle; cnt holds across the en=0 cycles.
5. thr changed 4->2 while cnt=2 in COUNT -> current run still needs 4 ones; the next run hits after 2. thr=0 -> flag never asserts, cnt stays 0.
6. HIT_W=2, 5 hits -> hit_cnt reads 1,2,3,3,3. clr mid-run with cnt=2 -> next cycle cnt=0, state IDLE, hit_cnt=0. rst pulsed low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/data_count_fsm.sv
// Counts qualifying ones (en & data) against a run-time threshold and pulses
// flag for one cycle after the terminal sample; also keeps a saturating hit counter.
//
// state | meaning
// IDLE  | no run in progress, cnt = 0, thr_q tracks thr each cycle
// COUNT | run in progress, 1 <= cnt < thr_q, thr_q frozen
module data_count_fsm #(
  parameter int CNT_W = 4,
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             data,
  input  logic             mode,
  input  logic [CNT_W-1:0] thr,
  output logic             flag,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic [HIT_W-1:0] hit_cnt
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] thr_q, thr_nx, cnt_nx;
  logic             hit;
  logic             q;

  assign q = en & data;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    thr_nx   = thr_q;
    hit      = 1'b0;
    case (state)
      IDLE: begin
        thr_nx = thr;
        cnt_nx = '0;
        if (q && thr == CNT_W'(1)) begin
          hit = 1'b1;
        end else if (q && thr > CNT_W'(1)) begin
          cnt_nx   = CNT_W'(1);
          state_nx = COUNT;
        end
      end
      COUNT: begin
        if (q) begin
          if (cnt == thr_q - CNT_W'(1)) begin
            hit      = 1'b1;
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end else if (en && mode) begin
          // consecutive mode: a qualified zero abandons the run
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      thr_q   <= '0;
      flag    <= 1'b0;
      busy    <= 1'b0;
      hit_cnt <= '0;
    end else if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      thr_q   <= '0;
      flag    <= 1'b0;
      busy    <= 1'b0;
      hit_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      thr_q <= thr_nx;
      flag  <= hit;
      busy  <= (state_nx == COUNT);
      if (hit && !(&hit_cnt)) hit_cnt <= hit_cnt + HIT_W'(1);
    end
  end

endmodule

// File: tb/tb_data_count_fsm.sv
// Self-checking bench for data_count_fsm: directed scenarios with literal
// expectations plus a randomized run against a behavioural reference model.
module tb_data_count_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic       data = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] thr = 4'd0;
  logic       flag, busy, flag_s, busy_s;
  logic [3:0] cnt, cnt_s;
  logic [7:0] hit_cnt;
  logic [1:0] hit_cnt_s;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_run = 0;
  int m_thr = 0;
  int m_hits = 0;
  bit m_flag = 0;

  data_count_fsm #(.CNT_W(4), .HIT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .data(data), .mode(mode), .thr(thr),
    .flag(flag), .cnt(cnt), .busy(busy), .hit_cnt(hit_cnt)
  );

  data_count_fsm #(.CNT_W(4), .HIT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .data(data), .mode(mode), .thr(thr),
    .flag(flag_s), .cnt(cnt_s), .busy(busy_s), .hit_cnt(hit_cnt_s)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_thr = 0; m_hits = 0; m_flag = 0;
  endtask

  // drive one sample, advance one clock, update the model, settle past the edge
  task automatic cycle(input logic c, input logic e, input logic d);
    clr = c; en = e; data = d;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      m_flag = 0;
      if (m_run == 0) begin
        m_thr = int'(thr);
        if (e && d && m_thr == 1) begin
          m_flag = 1; m_hits++;
        end else if (e && d && m_thr >= 2) begin
          m_run = 1;
        end
      end else if (e) begin
        if (d) begin
          if (m_run + 1 == m_thr) begin
            m_flag = 1; m_hits++; m_run = 0;
          end else begin
            m_run++;
          end
        end else if (mode) begin
          m_run = 0;
        end
      end
    end
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if ({flag, cnt, busy, hit_cnt, hit_cnt_s} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got flag=%0b cnt=%0d busy=%0b hit=%0d hit_s=%0d exp all 0",
               flag, cnt, busy, hit_cnt, hit_cnt_s);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_cumulative();
    logic d[6]  = '{1, 0, 1, 1, 0, 1};
    int   ec[6] = '{1, 1, 2, 3, 3, 0};
    cycle(1, 0, 0);
    thr = 4'd4; mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, d[i]);
      checks++;
      if (cnt !== 4'(ec[i]) || flag !== (i == 5)) begin
        failures++;
        $display("FAIL cumulative[%0d] got cnt=%0d flag=%0b exp cnt=%0d flag=%0b",
                 i, cnt, flag, ec[i], (i == 5));
      end
    end
    checks++;
    if (hit_cnt !== 8'd1) begin
      failures++; $display("FAIL cumulative_hits got=%0d exp=1", hit_cnt);
    end
  endtask

  task automatic test_consecutive();
    logic d[6]  = '{1, 1, 0, 1, 1, 1};
    int   ec[6] = '{1, 2, 0, 1, 2, 0};
    logic eb[6] = '{1, 1, 0, 1, 1, 0};
    cycle(1, 0, 0);
    thr = 4'd3; mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, d[i]);
      checks++;
      if (cnt !== 4'(ec[i]) || flag !== (i == 5) || busy !== eb[i]) begin
        failures++;
        $display("FAIL consecutive[%0d] got cnt=%0d flag=%0b busy=%0b exp cnt=%0d flag=%0b busy=%0b",
                 i, cnt, flag, busy, ec[i], (i == 5), eb[i]);
      end
    end
    checks++;
    if (hit_cnt !== 8'd1) begin
      failures++; $display("FAIL consecutive_hits got=%0d exp=1", hit_cnt);
    end
  endtask

  task automatic test_back_to_back_sat();
    cycle(1, 0, 0);
    thr = 4'd1; mode = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 1, 1);
      checks++;
      if (flag !== 1'b1 || busy !== 1'b0 || cnt !== 4'd0 || hit_cnt !== 8'(i)
          || hit_cnt_s !== 2'(sat(i, 3)) || flag_s !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back[%0d] got flag=%0b busy=%0b cnt=%0d hit=%0d hit_s=%0d exp flag=1 busy=0 cnt=0 hit=%0d hit_s=%0d",
                 i, flag, busy, cnt, hit_cnt, hit_cnt_s, i, sat(i, 3));
      end
    end
    cycle(0, 1, 0);
    checks++;
    if (flag !== 1'b0 || hit_cnt_s !== 2'd3) begin
      failures++; $display("FAIL sat_hold got flag=%0b hit_s=%0d exp flag=0 hit_s=3", flag, hit_cnt_s);
    end
  endtask

  task automatic test_enable();
    logic e[6]  = '{1, 0, 1, 0, 1, 1};
    int   ec[6] = '{1, 1, 2, 2, 3, 0};
    cycle(1, 0, 0);
    thr = 4'd4; mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(0, e[i], 1'b1);
      checks++;
      if (cnt !== 4'(ec[i]) || flag !== (i == 5)) begin
        failures++;
        $display("FAIL enable[%0d] got cnt=%0d flag=%0b exp cnt=%0d flag=%0b",
                 i, cnt, flag, ec[i], (i == 5));
      end
    end
  endtask

  task automatic test_thr_change();
    int   ec[6] = '{1, 2, 3, 0, 1, 0};
    logic ef[6] = '{0, 0, 0, 1, 0, 1};
    cycle(1, 0, 0);
    thr = 4'd4; mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) thr = 4'd2;
      cycle(0, 1, 1);
      checks++;
      if (cnt !== 4'(ec[i]) || flag !== ef[i]) begin
        failures++;
        $display("FAIL thr_change[%0d] got cnt=%0d flag=%0b exp cnt=%0d flag=%0b",
                 i, cnt, flag, ec[i], ef[i]);
      end
    end
    thr = 4'd0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 1);
      checks++;
      if (cnt !== 4'd0 || flag !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL thr_zero[%0d] got cnt=%0d flag=%0b busy=%0b exp 0 0 0", i, cnt, flag, busy);
      end
    end
    checks++;
    if (hit_cnt !== 8'd2) begin
      failures++; $display("FAIL thr_change_hits got=%0d exp=2", hit_cnt);
    end
  endtask

  task automatic test_clr_rst();
    cycle(1, 0, 0);
    thr = 4'd1; mode = 1'b0;
    cycle(0, 1, 1);
    thr = 4'd3;
    cycle(0, 1, 1);
    cycle(0, 1, 1);
    checks++;
    if (cnt !== 4'd2 || busy !== 1'b1 || hit_cnt !== 8'd1) begin
      failures++; $display("FAIL pre_clr got cnt=%0d busy=%0b hit=%0d exp 2 1 1", cnt, busy, hit_cnt);
    end
    cycle(1, 1, 1);
    checks++;
    if (cnt !== 4'd0 || busy !== 1'b0 || hit_cnt !== 8'd0 || flag !== 1'b0) begin
      failures++;
      $display("FAIL clr got cnt=%0d busy=%0b hit=%0d flag=%0b exp all 0", cnt, busy, hit_cnt, flag);
    end
    thr = 4'd1;
    cycle(0, 1, 1);
    thr = 4'd4;
    cycle(0, 1, 1);
    cycle(0, 1, 1);
    rst = 1'b0;
    #1;
    checks++;
    if (cnt !== 4'd0 || busy !== 1'b0 || hit_cnt !== 8'd0) begin
      failures++; $display("FAIL rst_midrun got cnt=%0d busy=%0b hit=%0d exp 0 0 0", cnt, busy, hit_cnt);
    end
    #1 rst = 1'b1;
    model_reset();
    thr = 4'd1;
    cycle(0, 1, 1);
    rst = 1'b0;
    #1;
    checks++;
    if (flag !== 1'b0 || hit_cnt !== 8'd0 || flag_s !== 1'b0) begin
      failures++; $display("FAIL rst_flag got flag=%0b hit=%0d exp 0 0", flag, hit_cnt);
    end
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    cycle(1, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) thr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                                       : 4'($urandom_range(0, 4));
      mode = 1'($urandom_range(0, 1));
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7));
      checks++;
      if (flag !== m_flag || cnt !== 4'(m_run) || busy !== (m_run != 0)
          || hit_cnt !== 8'(sat(m_hits, 255)) || hit_cnt_s !== 2'(sat(m_hits, 3))) begin
        failures++;
        $display("FAIL random[%0d] got flag=%0b cnt=%0d busy=%0b hit=%0d hit_s=%0d exp flag=%0b cnt=%0d busy=%0b hit=%0d hit_s=%0d",
                 i, flag, cnt, busy, hit_cnt, hit_cnt_s, m_flag, m_run, (m_run != 0),
                 sat(m_hits, 255), sat(m_hits, 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_cumulative();
    test_consecutive();
    test_back_to_back_sat();
    test_enable();
    test_thr_change();
    test_clr_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
